// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display controller: segment patterns,
// idle pin levels and FSM state encoding.
package seg_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CONV   = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;

  // {dp,g,f,e,d,c,b,a}, active high, dp never lit
  localparam logic [7:0] SEG_PAT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  localparam logic [7:0] COM_OFF    = 8'hFF;
  localparam logic [7:0] DATA_BLANK = 8'h00;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Nibble to seven-segment pattern lookup; purely combinational, no backpressure.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] pattern
);

  assign pattern = SEG_PAT[nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed 7-seg controller: double-dabble/hex capture, tear-free commit, scan.
// Decimal busy VALUE_W+1 cycles, hex 1 cycle; loads while busy are dropped.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int VALUE_W = 27,
  parameter int DIV     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  input  logic               hex_mode,
  input  logic               blank_lz,
  output logic               busy,
  output logic [DIGITS-1:0]  seg_COM,
  output logic [7:0]         seg_DATA
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int PAD_W = (VALUE_W > BCD_W) ? VALUE_W : BCD_W;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam longint unsigned DEC_MAX = pow10(DIGITS) - 1;
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [BCD_W-1:0] ALL_F     = {DIGITS{4'hF}};

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [VALUE_W-1:0] shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               sat_q;
  logic               blz_q;
  logic [BCD_W-1:0]   disp_q;
  logic               disp_blz_q;
  logic [DIV_W-1:0]   div_q;
  logic [IDX_W-1:0]   idx_q;

  logic [PAD_W-1:0]   value_pad;
  logic               hex_ovf;
  logic               dec_sat;
  logic [BCD_W-1:0]   bcd_adj;

  // Overflow is judged on the raw input so saturation never depends on BCD wrap
  assign value_pad = PAD_W'(value);
  assign hex_ovf   = |(value_pad >> BCD_W);
  assign dec_sat   = 64'(value) > DEC_MAX;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      sat_q      <= 1'b0;
      blz_q      <= 1'b0;
      disp_q     <= '0;
      disp_blz_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            blz_q <= blank_lz;
            cnt_q <= '0;
            if (hex_mode) begin
              bcd_q   <= hex_ovf ? ALL_F : value_pad[BCD_W-1:0];
              sat_q   <= 1'b0;
              state_q <= ST_COMMIT;
            end else begin
              bcd_q   <= '0;
              shift_q <= value;
              sat_q   <= dec_sat;
              state_q <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(VALUE_W - 1)) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // The only place the shown value changes, so a scan never mixes two values
          disp_q     <= sat_q ? ALL_NINES : bcd_q;
          disp_blz_q <= blz_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_W'(DIV - 1)) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  logic [3:0]       cur_nib;
  logic [7:0]       cur_pat;
  logic [BCD_W-1:0] disp_upper;
  logic             cur_blank;

  assign cur_nib    = disp_q[4*idx_q +: 4];
  assign disp_upper = disp_q >> (4 * idx_q);
  // Blank when this digit and everything above it is zero; digit 0 always shows
  assign cur_blank  = disp_blz_q && (idx_q != '0) && (disp_upper == '0);

  hex_to_7seg u_hex_to_7seg (
    .nibble  (cur_nib),
    .pattern (cur_pat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_COM  <= COM_OFF[DIGITS-1:0];
      seg_DATA <= DATA_BLANK;
    end else if (enable) begin
      seg_COM  <= ~(DIGITS'(1) << idx_q);
      seg_DATA <= cur_blank ? DATA_BLANK : cur_pat;
    end else begin
      seg_COM  <= COM_OFF[DIGITS-1:0];
      seg_DATA <= DATA_BLANK;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomised scoreboard bench for seg_display_ctrl with a digit-arithmetic reference model.
module tb_seg_display_ctrl;

  localparam int DIGITS  = 4;
  localparam int VALUE_W = 16;
  localparam int DIV     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic        hex_mode;
  logic        blank_lz;
  logic        busy;
  logic [3:0]  seg_COM;
  logic [7:0]  seg_DATA;

  always #5 clk = ~clk;

  seg_display_ctrl #(.DIGITS(DIGITS), .VALUE_W(VALUE_W), .DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .load     (load),
    .value    (value),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .busy     (busy),
    .seg_COM  (seg_COM),
    .seg_DATA (seg_DATA)
  );

  typedef struct {
    logic [31:0] pats;
    int          blen;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  logic en_d = 1'b0;

  logic [7:0] pat_tab [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Expected four digit patterns from plain base-10 / base-16 digit arithmetic
  function automatic logic [31:0] model(input int v, input bit hx, input bit bz);
    int d [4];
    int x;
    int hi;
    logic [31:0] r;
    x = hx ? v : ((v > 9999) ? 9999 : v);
    for (int i = 0; i < 4; i++) begin
      d[i] = hx ? (x % 16) : (x % 10);
      x    = hx ? (x / 16) : (x / 10);
    end
    hi = 0;
    for (int i = 0; i < 4; i++) if (d[i] != 0) hi = i;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = (bz && i > hi) ? 8'h00 : pat_tab[d[i]];
    return r;
  endfunction

  // Edge counter since reset release and the enable value each edge captured
  initial begin
    forever begin
      @(posedge clk);
      en_d = enable;
      if (rst) cyc = 0;
      else cyc++;
    end
  end

  // Monitor: pops an expectation on each busy rise, commits it to the expected display
  initial begin
    logic        in_busy;
    logic        have_pend;
    int          bcnt;
    int          commit_at;
    int          idx;
    exp_t        pend;
    logic [31:0] shown;
    logic [3:0]  exp_com;
    logic [3:0]  one;
    logic [7:0]  exp_dat;
    in_busy   = 1'b0;
    have_pend = 1'b0;
    bcnt      = 0;
    commit_at = -1;
    shown     = 32'h3F3F3F3F;
    one       = 4'b0001;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_com", 32'(seg_COM), 32'hF);
        chk("rst_data", 32'(seg_DATA), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        in_busy   = 1'b0;
        have_pend = 1'b0;
        commit_at = -1;
        exp_q.delete();
        shown     = 32'h3F3F3F3F;
      end else begin
        if (have_pend && commit_at == cyc) begin
          shown     = pend.pats;
          have_pend = 1'b0;
        end
        if (busy) begin
          if (!in_busy) begin
            in_busy = 1'b1;
            bcnt    = 0;
            if (exp_q.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_busy: busy=1 with no accepted load pending, required 0 (cycle %0d)", cyc);
            end else begin
              pend      = exp_q.pop_front();
              have_pend = 1'b1;
            end
          end
          bcnt++;
        end else if (in_busy) begin
          in_busy = 1'b0;
          if (have_pend) begin
            chk("busy_len", 32'(bcnt), 32'(pend.blen));
            commit_at = cyc + 1;
          end
        end
        if (cyc == 0 || !en_d) begin
          exp_com = 4'hF;
          exp_dat = 8'h00;
        end else begin
          idx     = ((cyc - 1) / DIV) % DIGITS;
          exp_com = ~(one << idx);
          exp_dat = shown[8*idx +: 8];
        end
        chk("scan_com", 32'(seg_COM), 32'(exp_com));
        chk("scan_data", 32'(seg_DATA), 32'(exp_dat));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [15:0] v, input logic hx, input logic bz, input bit acc);
    exp_t e;
    value    = v;
    hex_mode = hx;
    blank_lz = bz;
    load     = 1'b1;
    if (acc) begin
      e.pats = model(int'(v), hx, bz);
      e.blen = hx ? 1 : VALUE_W + 1;
      exp_q.push_back(e);
    end
    tick(1);
    load  = 1'b0;
    value = 16'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 100) begin
      tick(1);
      t++;
    end
    if (busy) begin
      n_chk++;
      $display("FAIL idle_timeout: busy=1 after 100 cycles, required 0");
    end
  endtask

  initial begin
    logic [15:0] v;
    logic        hx;
    logic        bz;
    rst      = 1'b1;
    enable   = 1'b1;
    load     = 1'b0;
    value    = '0;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(20);

    // 1234, plus a load landing in the commit cycle that must be dropped
    issue(16'd1234, 1'b0, 1'b0, 1'b1);
    tick(16);
    issue(16'd4321, 1'b0, 1'b0, 1'b0);
    wait_idle();
    tick(20);

    issue(16'd7, 1'b0, 1'b1, 1'b1);
    wait_idle();
    tick(20);
    issue(16'd7, 1'b0, 1'b0, 1'b1);
    wait_idle();
    tick(20);

    issue(16'd12345, 1'b0, 1'b0, 1'b1);
    wait_idle();
    tick(20);
    issue(16'hBEEF, 1'b1, 1'b0, 1'b1);
    wait_idle();
    tick(20);

    issue(16'd100, 1'b0, 1'b0, 1'b1);
    tick(5);
    issue(16'd200, 1'b0, 1'b0, 1'b0);
    wait_idle();
    tick(20);
    issue(16'd200, 1'b0, 1'b0, 1'b1);
    wait_idle();
    tick(20);

    // Reset in the middle of a conversion
    issue(16'd555, 1'b0, 1'b0, 1'b1);
    tick(5);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);

    issue(16'd9876, 1'b0, 1'b0, 1'b1);
    wait_idle();
    tick(10);
    enable = 1'b0;
    tick(10);
    enable = 1'b1;
    tick(20);

    for (int k = 0; k < 40; k++) begin
      v  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom_range(0, 65535));
      hx = 1'($urandom_range(0, 1));
      bz = 1'($urandom_range(0, 1));
      issue(v, hx, bz, 1'b1);
      if (!hx && $urandom_range(0, 2) == 0) begin
        tick(3);
        issue(16'($urandom), 1'b0, 1'b0, 1'b0);
      end
      wait_idle();
      if ($urandom_range(0, 4) == 0) enable = ~enable;
      tick($urandom_range(2, 24));
    end

    enable = 1'b1;
    tick(20);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Parametrised multiplexed seven-segment display controller: successor to the fixed 8-digit, 8-bit display unit. Accepts a VALUE_W-bit binary value through a load/busy handshake, converts it to DIGITS decimal digits with a sequential shift-add-3 (double-dabble) engine, or passes it through as hex, then scans the digits onto a common-anode style COM/DATA bus. Adds leading-zero blanking, saturation and tear-free display updates. Sits between the datapath and the board display pins.

## Interface
- DIGITS, 8: number of digits driven (1..8)
- VALUE_W, 27: width of input value
- DIV, 32: clock cycles each digit stays selected (>=2)
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous and active-high
- enable  in  1  1 = display on; 0 = all digits off
- load  in  1  single-cycle request; captures value/hex_mode when busy=0
- value  in  VALUE_W  binary value to show
- hex_mode  in  1  1 = show as hex, 0 = decimal
- blank_lz  in  1  1 = blank leading zeros
- busy  out  1  conversion in progress; load ignored
- seg_COM  out  DIGITS  active-low one-hot digit select, bit 0 = rightmost
- seg_DATA  out  8  active-high segments {dp,g,f,e,d,c,b,a}

## Operation
- FSM IDLE -> CONV -> COMMIT -> IDLE. IDLE: load=1 captures value, hex_mode, blank_lz; goes CONV (decimal) or COMMIT (hex).
- CONV: one shift-add-3 iteration per cycle, exactly VALUE_W cycles, into a 4*DIGITS-bit BCD register.
- Decimal saturation: value > 10^DIGITS-1 (checked at capture) commits all digits 9.
- Hex: digit i = value[4i+3:4i]; any set bit above 4*DIGITS commits all digits F.
- COMMIT: one cycle; copies result into the display register. Display register changes only here, so no torn values.
- load while busy: ignored, no queueing.
- Blanking: with blank_lz=1, every digit above the highest nonzero digit shows DATA=0; digit 0 always shown (value 0 shows "0").
- Patterns 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71; dp always 0.
- Scan: divider counts 0..DIV-1; on wrap digit index advances 0..DIGITS-1 and wraps to 0. Scan runs regardless of enable and busy.
- enable=0: seg_COM all 1, seg_DATA 0. The FSM still accepts loads.

## Timing
- Reset: seg_COM all 1, seg_DATA 0, busy 0, FSM IDLE, display register 0, divider 0, index 0.
- seg_COM/seg_DATA are registered: they reflect the index and display register one cycle late.
- Decimal: load sampled at edge N; busy=1 from N+1 for VALUE_W+1 cycles (CONV+COMMIT); display register updated at edge N+VALUE_W+1; pins show new digit one edge later.
- Hex: busy=1 for one cycle; pins update 2 edges after load sampled.
- load in the same cycle COMMIT completes is ignored (busy still 1).
- Reset mid-conversion: aborts; display returns to reset values; no partial commit.
- First digit after reset: index 0 selected from the first edge after rst deasserts (seg_COM bit 0 low if enable=1).

## Structure
- Package seg_pkg: 16-entry segment pattern constants, COM_OFF (all 1), DATA_BLANK (8'h00), FSM state typedef.
- One sub-module hex_to_7seg (4-bit nibble to 8-bit pattern). Instantiate once, after the digit mux, not per digit.
- Double-dabble engine, FSM, divider and scan mux stay in the top module.

## Test plan
Bench parameters: DIGITS=4, VALUE_W=16, DIV=4.
- Load 1234 decimal, enable=1 -> busy high 17 cycles; then per slot COM 1110/1101/1011/0111 with DATA 66/4F/5B/06, each held 4 cycles.
- Load 7, blank_lz=1 -> digit0 DATA 07; digits 1-3 DATA 00 with COM still cycling; repeat blank_lz=0 -> digits 1-3 show 3F.
- Load 12345 decimal -> all four digits 6F (9999). Load 16'hBEEF hex -> digits 0-3 show 71,79,79,7C; busy high 1 cycle.
- Load 100, then pulse load=200 during busy -> display stays 0100, later 200 load accepted only after busy falls; display never shows a mixed value.
- Assert rst at CONV cycle 5 -> COM all 1, DATA 0, busy 0 next cycle; display stays 0 after release.
- enable=0 during steady display -> COM 1111, DATA 00; re-enable -> scan resumes at current index with correct digits.
